// File: rtl/down_timer.sv
// Loadable down-counting timer with start/stop/ack handshake.
// DOWN_TIMER_AUTORELOAD_EN selects periodic (auto-reload) mode.
module down_timer #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [width-1:0] period,
  input  logic             start,
  input  logic             stop,
  input  logic             ack,
  input  logic             ena,
  output logic [width-1:0] q,
  output logic             busy,
  output logic             tick,
  output logic             expired
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [width-1:0] per_r;
  logic [width-1:0] q_nxt;
  logic [width-1:0] p_eff;
  logic             tick_nxt;
  logic             exp_nxt;
  logic             run;
  logic             do_stop;
  logic             do_start;
  logic             do_dec;

  assign run   = (state == RUN);
  assign busy  = run;
  assign p_eff = load ? period : per_r;

  // Mutually exclusive actions: stop > start > decrement.
  assign do_stop  = stop & run;
  assign do_start = ~stop & start & (p_eff != '0);
  assign do_dec   = ~stop & ~do_start & run & ena;

  always_comb begin
    state_nxt = state;
    q_nxt     = q;
    tick_nxt  = 1'b0;
    exp_nxt   = expired & ~ack;
    unique case (1'b1)
      do_stop: begin
        q_nxt     = '0;
        state_nxt = IDLE;
      end
      do_start: begin
        q_nxt     = p_eff;
        state_nxt = RUN;
      end
      do_dec: begin
        if (q > width'(1)) begin
          q_nxt = q - width'(1);
        end else begin
          tick_nxt = 1'b1;
          exp_nxt  = 1'b1;
`ifdef DOWN_TIMER_AUTORELOAD_EN
          if (per_r != '0) begin
            q_nxt     = per_r;
            state_nxt = RUN;
          end else begin
            q_nxt     = '0;
            state_nxt = IDLE;
          end
`else
          q_nxt     = '0;
          state_nxt = IDLE;
`endif
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      per_r   <= '0;
      q       <= '0;
      tick    <= 1'b0;
      expired <= 1'b0;
    end else begin
      state   <= state_nxt;
      q       <= q_nxt;
      tick    <= tick_nxt;
      expired <= exp_nxt;
      if (load) begin
        per_r <= period;
      end
    end
  end

endmodule

// File: tb/tb_down_timer.sv
// Directed self-checking bench for down_timer.
// Autoreload checks run when DOWN_TIMER_AUTORELOAD_EN is defined.
`timescale 1ns/1ps
module tb_down_timer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         load;
  logic         start;
  logic         stop;
  logic         ack;
  logic         ena;
  logic [W-1:0] period;
  logic [W-1:0] q;
  logic         busy;
  logic         tick;
  logic         expired;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  down_timer #(.width(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .period  (period),
    .start   (start),
    .stop    (stop),
    .ack     (ack),
    .ena     (ena),
    .q       (q),
    .busy    (busy),
    .tick    (tick),
    .expired (expired)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in;
    load  = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    ack   = 1'b0;
  endtask

  initial begin
    int bc;
`ifndef DOWN_TIMER_AUTORELOAD_EN
    int st_q[6] = '{3, 2, 2, 1, 1, 0};
`else
    int ar_q[8] = '{3, 2, 1, 3, 2, 1, 3, 2};
`endif
    rst_n  = 1'b0;
    period = '0;
    ena    = 1'b0;
    idle_in();
    repeat (2) step();
    chk("rst_q", q, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tick", tick, 0);
    chk("rst_exp", expired, 0);
    rst_n = 1'b1;
    step();

`ifndef DOWN_TIMER_AUTORELOAD_EN
    load   = 1'b1;
    period = 8'd5;
    ena    = 1'b1;
    step();
    idle_in();
    chk("load_q", q, 0);
    chk("load_busy", busy, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    bc = 0;
    for (int n = 0; n <= 5; n++) begin
      chk("cnt_q", q, 5 - n);
      chk("cnt_tick", tick, (n == 5) ? 1 : 0);
      if (busy) bc++;
      if (n < 5) step();
    end
    chk("cnt_busy_cycles", bc, 5);
    chk("cnt_exp", expired, 1);
    step();
    chk("tick_pulse", tick, 0);
    chk("exp_sticky", expired, 1);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("ack_clr", expired, 0);

    load   = 1'b1;
    period = 8'd3;
    start  = 1'b1;
    ena    = 1'b0;
    step();
    idle_in();
    chk("str_q0", q, 3);
    for (int i = 1; i <= 6; i++) begin
      ena = (i % 2 == 0);
      step();
      chk("str_q", q, st_q[i-1]);
      chk("str_tick", tick, (i == 6) ? 1 : 0);
    end
    ena = 1'b1;
    ack = 1'b1;
    step();
    ack = 1'b0;
`endif

    load   = 1'b1;
    period = 8'd0;
    start  = 1'b1;
    step();
    idle_in();
    chk("p0_busy", busy, 0);
    chk("p0_q", q, 0);

    load   = 1'b1;
    period = 8'd4;
    start  = 1'b1;
    ena    = 1'b1;
    step();
    idle_in();
    chk("stop_q4", q, 4);
    repeat (2) step();
    chk("stop_q2", q, 2);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop_q", q, 0);
    chk("stop_busy", busy, 0);
    chk("stop_tick", tick, 0);
    chk("stop_exp", expired, 0);
    start = 1'b1;
    step();
    chk("restart_q", q, 4);
    stop = 1'b1;
    step();
    idle_in();
    chk("ss_q", q, 0);
    chk("ss_busy", busy, 0);
    chk("ss_tick", tick, 0);
    repeat (3) begin
      step();
      chk("ss_idle_q", q, 0);
      chk("ss_idle_tick", tick, 0);
    end

    load   = 1'b1;
    period = 8'd5;
    start  = 1'b1;
    step();
    idle_in();
    chk("rt_q5", q, 5);
    repeat (3) step();
    chk("rt_q2", q, 2);
    load   = 1'b1;
    period = 8'd4;
    start  = 1'b1;
    step();
    idle_in();
    chk("rt_q", q, 4);
    chk("rt_tick", tick, 0);
    chk("rt_busy", busy, 1);
`ifndef DOWN_TIMER_AUTORELOAD_EN
    repeat (3) step();
    chk("ea_q1", q, 1);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("ea_q", q, 0);
    chk("ea_tick", tick, 1);
    chk("ea_exp", expired, 1);
    chk("ea_busy", busy, 0);
`else
    stop = 1'b1;
    step();
    stop = 1'b0;
`endif

    load   = 1'b1;
    period = 8'd5;
    start  = 1'b1;
    step();
    idle_in();
    repeat (2) step();
    chk("ar_pre_q", q, 3);
    chk("ar_pre_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_q", q, 0);
    chk("arst_busy", busy, 0);
    chk("arst_tick", tick, 0);
    chk("arst_exp", expired, 0);
    step();
    rst_n = 1'b1;
    repeat (3) begin
      step();
      chk("post_rst_q", q, 0);
      chk("post_rst_busy", busy, 0);
    end

`ifdef DOWN_TIMER_AUTORELOAD_EN
    load   = 1'b1;
    period = 8'd3;
    start  = 1'b1;
    ena    = 1'b1;
    step();
    idle_in();
    for (int i = 0; i < 8; i++) begin
      chk("auto_q", q, ar_q[i]);
      chk("auto_tick", tick, (i == 3 || i == 6) ? 1 : 0);
      chk("auto_busy", busy, 1);
      if (i < 7) step();
    end
    chk("auto_exp", expired, 1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("auto_stop_q", q, 0);
    chk("auto_stop_busy", busy, 0);
    repeat (4) begin
      step();
      chk("auto_stop_tick", tick, 0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
